// File: rtl/mem_arbiter_pkg.sv
// Shared defaults and helpers for the memory arbiter and its ID queue.
package mem_arbiter_pkg;

  localparam int unsigned DefNrPorts        = 2;
  localparam int unsigned DefAddrWidth      = 64;
  localparam int unsigned DefDataWidth      = 64;
  localparam int unsigned DefMaxOutstanding = 4;

  // Width of a port index; a single port still needs one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_id_fifo.sv
// In-order queue of granted port indices awaiting their downstream response.
module mem_arbiter_id_fifo
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned Depth = DefMaxOutstanding,
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] data_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [Width-1:0] head_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             push_eff, pop_eff;

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + PtrW'(1);
  endfunction

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rptr_q];

  assign push_eff = push_i & ~full_o;
  assign pop_eff  = pop_i & ~empty_o;

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push_eff) begin
      mem_d[wptr_q] = data_i;
      wptr_d        = next_ptr(wptr_q);
    end
    if (pop_eff) begin
      rptr_d = next_ptr(rptr_q);
    end
    unique case ({push_eff, pop_eff})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q  <= '{default: '0};
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin N:1 memory arbiter with grant lock and in-order response routing.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned NR_PORTS        = DefNrPorts,
  parameter int unsigned ADDR_WIDTH      = DefAddrWidth,
  parameter int unsigned DATA_WIDTH      = DefDataWidth,
  parameter int unsigned MAX_OUTSTANDING = DefMaxOutstanding
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic [NR_PORTS-1:0][ADDR_WIDTH-1:0]   in_address_i,
  input  logic [NR_PORTS-1:0][DATA_WIDTH-1:0]   in_wdata_i,
  input  logic [NR_PORTS-1:0]                   in_req_i,
  input  logic [NR_PORTS-1:0]                   in_we_i,
  input  logic [NR_PORTS-1:0][DATA_WIDTH/8-1:0] in_be_i,
  output logic [NR_PORTS-1:0]                   in_gnt_o,
  output logic [NR_PORTS-1:0]                   in_rvalid_o,
  output logic [DATA_WIDTH-1:0]                 in_rdata_o,
  output logic [ADDR_WIDTH-1:0]                 out_address_o,
  output logic [DATA_WIDTH-1:0]                 out_wdata_o,
  output logic                                  out_req_o,
  output logic                                  out_we_o,
  output logic [DATA_WIDTH/8-1:0]               out_be_o,
  input  logic                                  out_gnt_i,
  input  logic                                  out_rvalid_i,
  input  logic [DATA_WIDTH-1:0]                 out_rdata_i,
  output logic                                  resp_err_o
);

  localparam int unsigned IdxW = idx_width(NR_PORTS);

  logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0] lock_idx_q, lock_idx_d;
  logic            lock_q, lock_d;
  logic            resp_err_q, resp_err_d;

  logic [IdxW-1:0] winner;
  logic            found;
  logic            lock_hold;
  int unsigned     cand;
  logic            req_int;
  logic            transfer;
  logic            fifo_full, fifo_empty;
  logic [IdxW-1:0] fifo_head;
  logic            pop;

  // Winner: a still-requesting locked port, else first requester from rr_ptr.
  always_comb begin
    winner    = rr_ptr_q;
    found     = 1'b0;
    cand      = 0;
    lock_hold = lock_q & in_req_i[lock_idx_q];
    if (lock_hold) begin
      winner = lock_idx_q;
      found  = 1'b1;
    end else begin
      for (int unsigned i = 0; i < NR_PORTS; i++) begin
        cand = 32'(rr_ptr_q) + i;
        if (cand >= NR_PORTS) begin
          cand = cand - NR_PORTS;
        end
        if (!found && in_req_i[cand]) begin
          winner = IdxW'(cand);
          found  = 1'b1;
        end
      end
    end
  end

  // Outputs gated by rst_ni so they drop immediately on reset assertion.
  assign req_int  = rst_ni & (|in_req_i) & ~fifo_full;
  assign transfer = req_int & out_gnt_i;
  assign pop      = out_rvalid_i & ~fifo_empty;

  assign out_req_o     = req_int;
  assign out_address_o = in_address_i[winner];
  assign out_wdata_o   = in_wdata_i[winner];
  assign out_we_o      = in_we_i[winner];
  assign out_be_o      = in_be_i[winner];
  assign in_rdata_o    = out_rdata_i;
  assign resp_err_o    = resp_err_q;

  always_comb begin
    in_gnt_o    = '0;
    in_rvalid_o = '0;
    if (transfer) begin
      in_gnt_o[winner] = 1'b1;
    end
    if (pop && rst_ni) begin
      in_rvalid_o[fifo_head] = 1'b1;
    end
  end

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    resp_err_d = resp_err_q | (out_rvalid_i & fifo_empty);
    if (transfer) begin
      lock_d   = 1'b0;
      rr_ptr_d = (winner == IdxW'(NR_PORTS - 1)) ? '0 : winner + IdxW'(1);
    end else if (req_int) begin
      lock_d     = 1'b1;
      lock_idx_d = winner;
    end else if (lock_q && !in_req_i[lock_idx_q]) begin
      lock_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q   <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      resp_err_q <= 1'b0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      resp_err_q <= resp_err_d;
    end
  end

  mem_arbiter_id_fifo #(
    .Depth (MAX_OUTSTANDING),
    .Width (IdxW)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (transfer),
    .pop_i   (pop),
    .data_i  (winner),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head)
  );

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 NR_PORTS, 2, number of requester ports (>=2).
REQ-002 ADDR_WIDTH, 64, address width.
REQ-003 DATA_WIDTH, 64, data width; byte-enable width DATA_WIDTH/8.
REQ-004 MAX_OUTSTANDING, 4, max granted-but-unanswered transfers (power of two, >=1).
REQ-005 clk_i  in  1  single clock; all state on rising edge.
REQ-006 rst_ni  in  1  reset, asynchronous, active-low.
REQ-007 in_address_i  in  NR_PORTS x ADDR_WIDTH  per-port address.
REQ-008 in_wdata_i  in  NR_PORTS x DATA_WIDTH  per-port write data.
REQ-009 in_req_i  in  NR_PORTS  per-port request.
REQ-010 in_we_i  in  NR_PORTS  per-port write enable.
REQ-011 in_be_i  in  NR_PORTS x DATA_WIDTH/8  per-port byte enable.
REQ-012 in_gnt_o  out  NR_PORTS  per-port grant.
REQ-013 in_rvalid_o  out  NR_PORTS  per-port response valid.
REQ-014 in_rdata_o  out  DATA_WIDTH  response data, shared by all ports.
REQ-015 out_address_o / out_wdata_o / out_we_o / out_be_o  out  ADDR_WIDTH / DATA_WIDTH / 1 / DATA_WIDTH/8  downstream payload.
REQ-016 out_req_o  out  1  downstream request.
REQ-017 out_gnt_i / out_rvalid_i / out_rdata_i  in  1 / 1 / DATA_WIDTH  downstream grant, response valid, response data.
REQ-018 resp_err_o  out  1  sticky: response received with nothing outstanding.

Function
REQ-019 out_req_o SHALL be 1 iff some in_req_i bit is 1 and the ID queue is not full; combinational, zero added latency.
REQ-020 Winner SHALL be the locked port if lock is set, else the first requesting index at or after rr_ptr, wrapping modulo NR_PORTS.
REQ-021 Downstream payload SHALL be muxed from the winner; unspecified (may be any value) when out_req_o=0.
REQ-022 Transfer SHALL occur when out_req_o=1 and out_gnt_i=1; in_gnt_o[winner]=1 only in that cycle, all other in_gnt_o bits 0.
REQ-023 On out_req_o=1 without grant, lock SHALL set on the winner; lock SHALL clear on that port's transfer or if that port drops in_req_i.
REQ-024 On transfer, winner index SHALL be pushed to the ID queue and rr_ptr SHALL become (winner+1) mod NR_PORTS; otherwise rr_ptr holds.
REQ-025 Every transfer (read or write) SHALL be answered by exactly one out_rvalid_i, in order, no earlier than the cycle after its grant.
REQ-026 On out_rvalid_i=1 with queue non-empty: in_rvalid_o[head]=1 same cycle, in_rdata_o=out_rdata_i, head popped.
REQ-027 Queue full (count==MAX_OUTSTANDING) SHALL block new transfers even if a pop occurs in the same cycle.
REQ-028 Simultaneous push and pop when not full SHALL leave count unchanged.
REQ-029 out_rvalid_i=1 with queue empty SHALL be ignored (no in_rvalid_o) and SHALL set resp_err_o until reset.

Reset
REQ-030 While rst_ni=0: rr_ptr=0, lock clear, queue count 0, resp_err_o=0; in_gnt_o, in_rvalid_o, out_req_o forced 0 asynchronously.
REQ-031 Transfers outstanding at reset SHALL be discarded; their later responses SHALL be handled per REQ-029.

Structure
REQ-032 Package mem_arbiter_pkg SHALL hold default width constants and the port-index width helper (clog2 of NR_PORTS, min 1).
REQ-033 ID queue SHALL be sub-module mem_arbiter_id_fifo (depth MAX_OUTSTANDING, width port-index) with push, pop, full, empty, head.

Verification
REQ-034 NR_PORTS=2, both req constant, out_gnt_i=1, rvalid 2 cycles after each grant -> grants 0,1,0,1; in_rvalid_o 0,1,0,1.
REQ-035 Port 0 wins, out_gnt_i=0 for 3 cycles, port 1 req meanwhile -> payload stays port 0's, port 0 granted cycle 4, port 1 cycle 5.
REQ-036 MAX_OUTSTANDING=4, no rvalid -> exactly 4 grants then out_req_o=0; one rvalid -> grant resumes the following cycle.
REQ-037 Count=4 with rvalid and req same cycle -> no grant that cycle, grant next; count=2 push+pop -> count stays 2.
REQ-038 out_rvalid_i with queue empty -> all in_rvalid_o=0, resp_err_o=1 and held across later traffic.
REQ-039 NR_PORTS=3, reset mid-traffic with 3 outstanding -> outputs 0 immediately; after release only port 2 requesting -> granted first cycle, rr_ptr=0.
